// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer between the UART receiver and the APB register
// block. Captures each completed character on the rising edge of rx_done,
// acknowledges the receiver, presents the oldest entry show-ahead, drives RTS
// from the fill level with hysteresis and flags dropped characters.
// Optional feature macro: UART_RX_FIFO_TIMEOUT_EN (adds rx_timeout + idle counter).
module uart_rx_fifo #(
    parameter int DEPTH          = 16,
    parameter int RTS_THRESHOLD  = 12,
    parameter int RTS_HYST       = 4,
    parameter int TIMEOUT_CYCLES = 4340
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [7:0]               rx_data,
    input  logic                     rx_done,
    input  logic                     parity_error,
    output logic                     host_read_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     rd_parity_err,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overrun,
    input  logic                     overrun_clr,
    input  logic                     flush,
`ifdef UART_RX_FIFO_TIMEOUT_EN
    output logic                     rx_timeout,
`endif
    output logic                     rts_n
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] RTS_HI_LVL = PW'(RTS_THRESHOLD);
    localparam logic [PW-1:0] RTS_LO_LVL = PW'(RTS_THRESHOLD - RTS_HYST);

    logic [8:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] level_q, level_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic [8:0]    head_q, head_d;
    logic          rx_done_q;
    logic          ack_q, ack_d;
    logic          overrun_q, overrun_d;
    logic          rts_n_q, rts_n_d;

    logic          capture_s;
    logic          pop_s;
    logic          wr_s;
    logic          ovr_set_s;
    logic [8:0]    wr_entry_s;
    logic [8:0]    head_next_s;

    // Datapath decisions: capture edge, pop, write acceptance, pointer and flag next-state.
    always_comb begin
        capture_s  = rx_done & ~rx_done_q;
        wr_entry_s = {parity_error, rx_data};
        // flush owns the read pointer, so a pop in the same cycle has no effect
        pop_s      = rd_en & ~empty_q & ~flush;
        // when full, a simultaneous pop frees the slot the write needs
        wr_s       = capture_s & ~flush & (~full_q | pop_s);
        ovr_set_s  = capture_s & ~flush & full_q & ~pop_s;

        wr_ptr_d   = wr_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        level_d = wr_ptr_d - rd_ptr_d;
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);

        // the new head can be the entry being written this very cycle
        if (wr_s && (rd_ptr_d[AW-1:0] == wr_ptr_q[AW-1:0])) begin
            head_next_s = wr_entry_s;
        end else begin
            head_next_s = mem_q[rd_ptr_d[AW-1:0]];
        end
        // output holds its last value once the FIFO drains
        head_d = empty_d ? head_q : head_next_s;

        // a new overrun event beats a simultaneous clear
        if (ovr_set_s) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        ack_d = capture_s;

        // RTS hysteresis driven by the registered level, so it lags level by a cycle
        if (!rts_n_q && (level_q >= RTS_HI_LVL)) begin
            rts_n_d = 1'b1;
        end else if (rts_n_q && (level_q <= RTS_LO_LVL)) begin
            rts_n_d = 1'b0;
        end else begin
            rts_n_d = rts_n_q;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            head_q    <= 9'h000;
            rx_done_q <= 1'b0;
            ack_q     <= 1'b0;
            overrun_q <= 1'b0;
            rts_n_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            head_q    <= head_d;
            rx_done_q <= rx_done;
            ack_q     <= ack_d;
            overrun_q <= overrun_d;
            rts_n_q   <= rts_n_d;
        end
    end

    // Character storage; entries are only read after being written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_entry_s;
        end
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT_CYCLES);

    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic        rx_timeout_q, rx_timeout_d;
    logic        activity_s;

    // Idle counter: cleared by any activity or an empty FIFO, saturating at the timeout.
    always_comb begin
        activity_s = capture_s | pop_s | flush;
        if (activity_s || (level_q == '0)) begin
            idle_cnt_d = 16'd0;
        end else if (idle_cnt_q >= TIMEOUT_C) begin
            idle_cnt_d = TIMEOUT_C;
        end else begin
            idle_cnt_d = idle_cnt_q + 16'd1;
        end
        if (activity_s) begin
            rx_timeout_d = 1'b0;
        end else if (idle_cnt_d == TIMEOUT_C) begin
            rx_timeout_d = 1'b1;
        end else begin
            rx_timeout_d = rx_timeout_q;
        end
    end

    // Timeout registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt_q   <= 16'd0;
            rx_timeout_q <= 1'b0;
        end else begin
            idle_cnt_q   <= idle_cnt_d;
            rx_timeout_q <= rx_timeout_d;
        end
    end

    assign rx_timeout = rx_timeout_q;
`endif

    assign host_read_data = ack_q;
    assign rd_data        = head_q[7:0];
    assign rd_parity_err  = head_q[8];
    assign empty          = empty_q;
    assign full           = full_q;
    assign level          = level_q;
    assign overrun        = overrun_q;
    assign rts_n          = rts_n_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed test-plan scenarios plus
// randomized traffic checked against a queue-based reference model. Popped
// bytes and acknowledge pulses go through scoreboards consumed by a monitor.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int TH    = 12;
    localparam int HY    = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       parity_error;
    logic       host_read_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_parity_err;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic       overrun;
    logic       overrun_clr;
    logic       flush;
    logic       rts_n;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DEPTH(DEPTH), .RTS_THRESHOLD(TH), .RTS_HYST(HY), .TIMEOUT_CYCLES(4340)
    ) dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_done(rx_done),
        .parity_error(parity_error), .host_read_data(host_read_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_parity_err(rd_parity_err),
        .empty(empty), .full(full), .level(level), .overrun(overrun),
        .overrun_clr(overrun_clr), .flush(flush), .rts_n(rts_n)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [8:0] mq[$];      // stored entries, oldest first
    logic [8:0] exp_q[$];   // expected bytes for pops issued
    bit         ack_q[$];   // expected acknowledge pulses
    bit         m_ovr;
    bit         m_rts;
    logic [8:0] m_last;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        ack_q.delete();
        m_ovr  = 1'b0;
        m_rts  = 1'b0;
        m_last = 9'h000;
    endtask

    // One clock cycle of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic step(bit cap, logic [7:0] d, bit pe, bit rd, bit fl, bit clr);
        int  old_lvl;
        bit  pop;
        bit  was_full;
        bit  ovr_set;
        rx_done      = cap;
        rx_data      = d;
        parity_error = pe;
        rd_en        = rd;
        flush        = fl;
        overrun_clr  = clr;

        old_lvl = mq.size();
        if (!m_rts && old_lvl >= TH) m_rts = 1'b1;
        else if (m_rts && old_lvl <= TH - HY) m_rts = 1'b0;

        ovr_set = 1'b0;
        if (cap) ack_q.push_back(1'b1);
        if (fl) begin
            mq.delete();
        end else begin
            pop      = rd && (mq.size() > 0);
            was_full = (mq.size() == DEPTH);
            if (pop) begin
                exp_q.push_back(mq[0]);
                void'(mq.pop_front());
            end
            if (cap) begin
                if (!was_full || pop) mq.push_back({pe, d});
                else ovr_set = 1'b1;
            end
        end
        if (ovr_set) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        if (mq.size() > 0) m_last = mq[0];

        @(posedge clk);
        #1;
        chk("level",   level,          mq.size());
        chk("empty",   empty,          mq.size() == 0);
        chk("full",    full,           mq.size() == DEPTH);
        chk("overrun", overrun,        m_ovr);
        chk("rts_n",   rts_n,          m_rts);
        chk("ack",     host_read_data, cap);
        chk("head",    {rd_parity_err, rd_data}, m_last);
    endtask

    task automatic capture(logic [7:0] d, bit pe);
        step(1'b1, d, pe, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop1();
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_flush();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic mid_reset();
        reset_n = 1'b0;
        rx_done = 1'b0; rd_en = 1'b0; flush = 1'b0; overrun_clr = 1'b0;
        #2;
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_ack", host_read_data, 0);
        chk("rst_rts", rts_n, 0);
        chk("rst_rd_data", {rd_parity_err, rd_data}, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Monitor: consumes scoreboard entries whenever the DUT pops or acknowledges.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rd_en && !empty && !flush) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL pop_unexpected: got %0h expected none", {rd_parity_err, rd_data});
                end else begin
                    chk("pop_data", {rd_parity_err, rd_data}, exp_q.pop_front());
                end
            end
            if (host_read_data) begin
                if (ack_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL ack_unexpected: got 1 expected no pulse");
                end else begin
                    void'(ack_q.pop_front());
                end
            end
        end
    end

    initial begin
        bit prev_cap;
        bit cap, rd, fl, clr;
        int rd_div;
        reset_n = 1'b0; rx_data = 8'h00; rx_done = 1'b0; parity_error = 1'b0;
        rd_en = 1'b0; overrun_clr = 1'b0; flush = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("reset_level", level, 0);
        chk("reset_empty", empty, 1);
        chk("reset_rts", rts_n, 0);
        chk("reset_rd_data", {rd_parity_err, rd_data}, 0);
        reset_n = 1'b1;

        // three characters, show-ahead head and pops
        capture(8'h41, 1'b0);
        capture(8'h42, 1'b1);
        capture(8'h43, 1'b0);
        chk("tp1_level", level, 3);
        chk("tp1_head", {rd_parity_err, rd_data}, 9'h041);
        pop1();
        chk("tp1_head2", {rd_parity_err, rd_data}, 9'h142);
        pop1();
        chk("tp1_head3", rd_data, 8'h43);
        pop1();
        chk("tp1_empty", empty, 1);
        chk("tp1_hold", rd_data, 8'h43);
        pop1();  // pop while empty is ignored
        chk("tp1_empty_pop", level, 0);

        // fill, overrun, clear
        for (int i = 0; i < DEPTH; i++) capture(8'(8'h10 + i), 1'(i % 3 == 0));
        chk("tp2_full", full, 1);
        capture(8'hEE, 1'b0);
        chk("tp2_overrun", overrun, 1);
        chk("tp2_level", level, 16);
        chk("tp2_head", rd_data, 8'h10);
        pop1();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("tp2_ovr_clr", overrun, 0);
        do_flush();

        // full with simultaneous capture and pop
        for (int i = 0; i < DEPTH; i++) capture(8'(8'h80 + i), 1'b0);
        step(1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("tp3_level", level, 16);
        chk("tp3_no_ovr", overrun, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH - 1; i++) pop1();
        chk("tp3_new_head", {rd_parity_err, rd_data}, 9'h15A);
        pop1();
        chk("tp3_empty", empty, 1);

        // RTS hysteresis
        for (int i = 0; i < TH; i++) capture(8'(i), 1'b0);
        chk("tp4_rts_hi", rts_n, 1);
        for (int i = 0; i < 3; i++) pop1();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("tp4_rts_hold", rts_n, 1);
        pop1();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("tp4_rts_lo", rts_n, 0);
        do_flush();

        // flush coinciding with a capture edge, overrun preset
        for (int i = 0; i < DEPTH + 1; i++) capture(8'(i), 1'b0);
        for (int i = 0; i < DEPTH - 5; i++) pop1();
        chk("tp5_level5", level, 5);
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("tp5_level", level, 0);
        chk("tp5_empty", empty, 1);
        chk("tp5_ovr_kept", overrun, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        // randomized traffic with varying read pressure and one mid-run reset
        prev_cap = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                mid_reset();
                prev_cap = 1'b0;
            end
            rd_div = ((i / 200) % 2 == 0) ? 6 : 2;
            cap = !prev_cap && ($urandom_range(0, 1) == 1);
            fl  = ($urandom_range(0, 63) == 0);
            rd  = !fl && ($urandom_range(0, rd_div - 1) == 0);
            clr = ($urandom_range(0, 15) == 0);
            step(cap, 8'($urandom), 1'($urandom), rd, fl, clr);
            prev_cap = cap;
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pops_drained", exp_q.size(), 0);
        chk("acks_drained", ack_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver.
- Captures each completed character (data byte plus its parity-error flag) when the receiver signals done, and acknowledges the receiver with host_read_data.
- Presents characters to the APB register block through a show-ahead pop interface.
- Generates RTS flow control from fill level with hysteresis, and flags overruns.

Parameters:
- DEPTH, 16, number of entries; power of 2, minimum 4.
- RTS_THRESHOLD, 12, level at or above which rts_n deasserts (goes high); must be ≤ DEPTH.
- RTS_HYST, 4, rts_n reasserts (goes low) when level ≤ RTS_THRESHOLD - RTS_HYST; must be < RTS_THRESHOLD.
- TIMEOUT_CYCLES, 4340, idle clk cycles before the character timeout fires; used only with the optional feature.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- rx_data  in  8  character from the receiver; valid while rx_done is high.
- rx_done  in  1  receiver done level; held high until acknowledged.
- parity_error  in  1  parity result from the receiver, sampled with rx_data.
- host_read_data  out  1  one-cycle acknowledge pulse to the receiver.
- rd_en  in  1  APB pop request.
- rd_data  out  8  head-entry byte (show-ahead).
- rd_parity_err  out  1  parity flag of the head entry.
- empty  out  1  level == 0.
- full  out  1  level == DEPTH.
- level  out  $clog2(DEPTH)+1  current entry count.
- overrun  out  1  sticky; a character was dropped.
- overrun_clr  in  1  clears overrun.
- flush  in  1  synchronous flush.
- rts_n  out  1  flow control to the peer; 0 = ready to receive.

Behaviour:
- Reset values:
  - level = 0, empty = 1, full = 0, overrun = 0, host_read_data = 0, rts_n = 0.
  - rd_data = 0, rd_parity_err = 0.
  - Pointers = 0; the rx_done delay register = 0.
- Storage: DEPTH x 9-bit array {parity_error, rx_data}.
  - Read and write pointers are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - full = (addresses equal and wrap bits differ). empty = pointers equal.
- Capture: on the rising edge of rx_done (rx_done=1 and its delayed copy=0), sample rx_data and parity_error in the same cycle.
  - Not full: write the entry at the write pointer and increment it.
  - Full: drop the character and set overrun = 1.
  - host_read_data pulses high for exactly one cycle, the cycle after the capture edge, whether the character was stored or dropped.
- Pop: rd_en=1 with empty=0 increments the read pointer. rd_data and rd_parity_err always reflect the head entry; they hold the last value when empty. rd_en while empty is ignored: no state change, no error.
- Simultaneous write and pop:
  - Not full: both take effect; level is unchanged.
  - Full: the pop frees a slot and the write is accepted; no overrun is raised.
- Capture and read share one cycle; level updates one cycle after the event.
- flush: read pointer := write pointer, so level = 0.
  - overrun is not cleared by flush.
  - A capture edge in the same cycle as flush: the byte is discarded without setting overrun; host_read_data still pulses.
- overrun_clr clears overrun. If overrun_clr coincides with a new overrun event, set wins.
- rts_n is registered and updates one cycle after level changes:
  - 0 -> 1 when level ≥ RTS_THRESHOLD.
  - 1 -> 0 when level ≤ RTS_THRESHOLD - RTS_HYST.
  - Otherwise it holds.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Any character captured in the same cycle is lost.

Optional Feature:
- Macro UART_RX_FIFO_TIMEOUT_EN.
- Defined:
  - Adds output rx_timeout (1 bit, reset 0) and a 16-bit idle counter.
  - The counter clears on any capture, pop, or flush, and whenever level == 0; otherwise it increments each cycle.
  - When the counter reaches TIMEOUT_CYCLES, rx_timeout sets; it clears on the next pop, capture, or flush.
  - The counter saturates at TIMEOUT_CYCLES.
- Undefined: no rx_timeout port and no counter logic.

Test Plan:
- Reset, then three capture edges carrying 0x41, 0x42 (parity_error=1), 0x43 -> each followed by one host_read_data pulse; level = 3; rd_data = 0x41, rd_parity_err = 0; after two pops rd_data = 0x43; after three pops empty = 1.
- Sixteen captures fill the FIFO -> full = 1. A 17th capture -> host_read_data pulses, overrun = 1, level stays 16. Pop -> rd_data is the first byte. overrun_clr -> overrun = 0.
- FIFO full and a capture coincides with rd_en -> level stays 16, no overrun; the new byte is read out 16 pops later.
- Fill to 12 -> rts_n = 1 one cycle later. Pop to 9 -> rts_n stays 1. Pop to 8 -> rts_n = 0.
- Level 5 with a capture edge in the same cycle as flush -> level = 0, empty = 1, overrun unchanged, host_read_data pulses.
- With UART_RX_FIFO_TIMEOUT_EN and TIMEOUT_CYCLES=20: one byte stored, then idle -> rx_timeout rises 20 cycles after the capture; one pop -> rx_timeout = 0.
